// File: rtl/afifo_pkg.sv
// Shared constants, buffer op encoding and the assertion helper for the
// read side of the async FIFO.
`ifndef AFIFO_ASSERT
`define AFIFO_ASSERT(name, clk, rst_n, prop, msg) \
    name: assert property (@(posedge clk) disable iff (!(rst_n)) (prop)) \
        else $error("%m: %s", msg);
`endif

package afifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned OCC_W              = 2;
    localparam int unsigned BUF_DEPTH          = 2;

    // {push, pop} as seen by the output buffer in one cycle.
    typedef enum logic [1:0] {
        OpIdle = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpBoth = 2'b11
    } buf_op_e;

    function automatic buf_op_e buf_op(input logic push, input logic pop);
        return buf_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO-ordered output buffer. The head is always a register, so the
// stream data never sees the FIFO read port combinationally.
module rd_skid_buf
    import afifo_pkg::*;
#(
    parameter int unsigned DataWidth = DEFAULT_DATA_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [OCC_W-1:0]     occ_o,
    output logic [DataWidth-1:0] head_o
);

    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [DataWidth-1:0] head_q, head_d;
    logic [DataWidth-1:0] tail_q, tail_d;
    buf_op_e              op;

    assign op = buf_op(push_i, pop_i);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (clear_i) begin
            occ_d = '0;
        end else begin
            unique case (op)
                OpPush: begin
                    if (occ_q == 2'd0) begin
                        head_d = push_data_i;
                        occ_d  = 2'd1;
                    end else begin
                        tail_d = push_data_i;
                        occ_d  = 2'd2;
                    end
                end
                OpPop: begin
                    if (occ_q == 2'd2) begin
                        head_d = tail_q;
                    end
                    occ_d = occ_q - 2'd1;
                end
                // Occupancy is unchanged; the captured word lands behind
                // whatever remains after the head leaves.
                OpBoth: begin
                    if (occ_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end else begin
                        head_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

    `AFIFO_ASSERT(a_no_overflow, clk_i, rst_ni,
                  !(push_i && !pop_i && !clear_i && occ_q == 2'd2),
                  "capture into a full buffer without a pop")
    `AFIFO_ASSERT(a_no_underflow, clk_i, rst_ni,
                  !(pop_i && !clear_i && occ_q == 2'd0),
                  "pop from an empty buffer")

endmodule

// File: rtl/afifo_read_ctrl.sv
// Read-side drain controller: pops the async FIFO whenever the output buffer
// has room and streams the words out on valid/ready at one word per cycle.
module afifo_read_ctrl
    import afifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  read_clock,
    input  logic                  read_reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy
);

    localparam logic [OCC_W:0] PendLimit = (OCC_W + 1)'(BUF_DEPTH);

    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [OCC_W-1:0]     occ;
    logic [OCC_W:0]       pending;
    logic                 xfer;
    logic                 capture;

    assign xfer = out_valid & out_ready;

    // Words already owed to the buffer, less the one leaving this cycle; one
    // bit wider than occ so occ + inflight cannot wrap.
    assign pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, xfer};

    assign fifo_read_en = read_reset & ~fifo_empty & ~flush & (pending < PendLimit);

    // A word landing in the flush cycle is dropped along with the buffer.
    assign capture = inflight_q & ~flush;

    always_comb begin
        inflight_d = fifo_read_en;
        count_d    = count_q + CNT_WIDTH'(xfer);
    end

    always_ff @(posedge read_clock or negedge read_reset) begin
        if (!read_reset) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    rd_skid_buf #(
        .DataWidth (DATA_WIDTH)
    ) u_skid_buf (
        .clk_i       (read_clock),
        .rst_ni      (read_reset),
        .clear_i     (flush),
        .push_i      (capture),
        .push_data_i (fifo_read_data),
        .pop_i       (xfer),
        .occ_o       (occ),
        .head_o      (out_data)
    );

    assign out_valid  = (occ != '0);
    assign busy       = out_valid | inflight_q;
    assign word_count = count_q;

    `AFIFO_ASSERT(a_pending_bound, read_clock, read_reset,
                  ({1'b0, occ} + {{OCC_W{1'b0}}, inflight_q}) <= PendLimit,
                  "more words owed than the buffer can hold")

endmodule
